update_search_n: RTL
====================

UPDATE_SEARCH_N -- requirements
Module: update_search_n

Interface
REQ-001 SHALL have parameter CH, default 2: number of independent search channels.
REQ-002 SHALL have parameter SLOTS, default 4: entries per row word; power of two, >=2; SW = log2(SLOTS).
REQ-003 SHALL have parameters IDX_W, default 16: column index width; VAL_W, default 48: element value width; EW = IDX_W+VAL_W.
REQ-004 SHALL have parameter ROW_W, default 11: row-word number width.
REQ-005 SHALL have parameter MAX_WORDS, default 8: word limit per search (used only with REQ-027).
REQ-006 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  synchronous, active-low.
REQ-007 SHALL have ports: start  in  CH  per-channel search request pulse; abort  in  CH  per-channel cancel.
REQ-008 SHALL have ports: key  in  CH*IDX_W  column index searched for; diag_pos  in  CH*SW  diagonal slot in first word.
REQ-009 SHALL have ports: word  in  CH*SLOTS*EW  row word, slot 0 at MSBs, entry = {idx, val}; word_valid  in  CH; row_end  in  CH  word is last of row; row_no  in  CH*ROW_W.
REQ-010 SHALL have ports: word_ready  out  CH; busy  out  CH; done  out  CH  one-cycle completion pulse; found  out  CH; timeout  out  CH.
REQ-011 SHALL have ports: elem  out  CH*VAL_W  matched value; pos  out  CH*(ROW_W+SW)  {row_no, slot} of match.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, FIRST, SCAN, DONE; channel c uses only slice c of every vector.
REQ-013 IDLE: start=1 SHALL latch key and diag_pos, clear found/timeout, go to FIRST next cycle; start outside IDLE SHALL be ignored.
REQ-014 word_ready SHALL be 1 exactly in FIRST and SCAN; a word is accepted on a cycle with word_valid=1 and word_ready=1.
REQ-015 FIRST: accepted word SHALL be compared only in slots strictly greater than latched diag_pos; slots <= diag_pos SHALL never match.
REQ-016 SCAN: accepted word SHALL be compared in all SLOTS slots.
REQ-017 Multiple matching slots in one word SHALL resolve to the lowest slot number.
REQ-018 On match: elem <= matched val, pos <= {row_no, slot}, found <= 1, next state DONE.
REQ-019 No match and row_end=1: found stays 0, elem/pos unchanged, next state DONE.
REQ-020 No match and row_end=0: next state SCAN.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; found, elem, pos, timeout SHALL hold until next accepted start.
REQ-022 Latency: word accepted in cycle t SHALL yield done=1 in cycle t+1 (registered result); min start-to-done = 3 cycles.
REQ-023 busy SHALL be 1 in FIRST, SCAN, DONE.
REQ-024 abort=1 in any state SHALL force IDLE next cycle without done; found/timeout cleared; abort has priority over start and word acceptance in the same cycle.
REQ-025 Word cycles with word_valid=0 SHALL stall the FSM with no state change.

Reset
REQ-026 reset=0 at a clock edge SHALL force all channels to IDLE and all outputs (word_ready, busy, done, found, timeout, elem, pos) to 0, overriding start/abort/word_valid, including mid-search.

Configuration
REQ-027 With macro UPDATE_SEARCH_TIMEOUT_EN defined: per-channel word counter cleared at start, incremented per accepted word; if MAX_WORDS words accepted with no match and no row_end, channel SHALL go to DONE with found=0, timeout=1; a match or row_end on the MAX_WORDS-th word takes precedence (timeout=0).
REQ-028 Without UPDATE_SEARCH_TIMEOUT_EN: no counter; timeout tied to 0; search runs until match, row_end or abort.

Verification
REQ-029 Ch0 key=0x0012, diag_pos=0, word slots idx {0x0005,0x0012,0x0030,0x0012}, vals 1..4, row_no=7, row_end=1 -> done one cycle later, found=1, elem=2, pos={7,01}.
REQ-030 Ch1 key=0x0005, diag_pos=2, first word slot1 idx=0x0005 (masked), row_end=0; second word slot0 idx=0x0005 val=0xABC, row_no=8 -> found=1, elem=0xABC, pos={8,00}.
REQ-031 Both channels started same cycle, ch0 hits on word 1, ch1 misses with row_end=1 on word 2 -> ch0 done/found=1 first; ch1 done with found=0, elem/pos unchanged.
REQ-032 Timeout macro defined, MAX_WORDS=8, 8 non-matching words row_end=0 -> done, found=0, timeout=1; macro undefined, same stimulus -> still in SCAN, busy=1.
REQ-033 reset=0 during SCAN, then abort=1 during another SCAN with word_valid=1 and matching word -> both return IDLE, all outputs 0, no done pulse.

Source files
------------

// File: rtl/update_search_n.sv
// Purpose : per-channel column-index search over a stream of row words; first word masked at/below the diagonal slot.
// Latency : an accepted word yields the registered result and a one-cycle done pulse on the next cycle; start-to-done is 3 cycles minimum.
// Backpressure: word_ready_o is high only while a channel is searching; word_valid_i low stalls the channel. Optional macro: UPDATE_SEARCH_TIMEOUT_EN.
module update_search_n #(
    parameter int CH        = 2,
    parameter int SLOTS     = 4,
    parameter int IDX_W     = 16,
    parameter int VAL_W     = 48,
    parameter int ROW_W     = 11,
    parameter int MAX_WORDS = 8,
    localparam int SW       = $clog2(SLOTS),
    localparam int EW       = IDX_W + VAL_W,
    localparam int PW       = ROW_W + SW
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [CH-1:0]         start_i,
    input  logic [CH-1:0]         abort_i,
    input  logic [CH*IDX_W-1:0]   key_i,
    input  logic [CH*SW-1:0]      diag_pos_i,
    input  logic [CH*SLOTS*EW-1:0] word_i,
    input  logic [CH-1:0]         word_valid_i,
    input  logic [CH-1:0]         row_end_i,
    input  logic [CH*ROW_W-1:0]   row_no_i,
    output logic [CH-1:0]         word_ready_o,
    output logic [CH-1:0]         busy_o,
    output logic [CH-1:0]         done_o,
    output logic [CH-1:0]         found_o,
    output logic [CH-1:0]         timeout_o,
    output logic [CH*VAL_W-1:0]   elem_o,
    output logic [CH*PW-1:0]      pos_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef UPDATE_SEARCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
`endif

    // Reject configurations the slot decode and word limit cannot represent.
    if (SLOTS < 2 || (SLOTS & (SLOTS - 1)) != 0 || MAX_WORDS < 1) begin : g_bad_cfg
        $error("update_search_n: SLOTS must be a power of two >= 2 and MAX_WORDS >= 1");
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        state_t              state_q;
        logic [IDX_W-1:0]    key_q;
        logic [SW-1:0]       diag_q;
        logic                found_q;
        logic                timeout_q;
        logic [VAL_W-1:0]    elem_q;
        logic [PW-1:0]       pos_q;

        logic [SLOTS*EW-1:0] row_word;
        logic [ROW_W-1:0]    row_no;
        logic [IDX_W-1:0]    slot_idx [SLOTS];
        logic [VAL_W-1:0]    slot_val [SLOTS];
        logic                searching;
        logic                hit;
        logic [SW-1:0]       hit_slot;
        logic [VAL_W-1:0]    hit_val;
        logic                limit_hit;

        assign row_word  = word_i[c*SLOTS*EW +: SLOTS*EW];
        assign row_no    = row_no_i[c*ROW_W +: ROW_W];
        assign searching = (state_q == S_FIRST) || (state_q == S_SCAN);

        // Entries are packed {idx, val} with slot 0 in the most significant position.
        for (genvar s = 0; s < SLOTS; s++) begin : g_slot
            assign slot_idx[s] = row_word[(SLOTS-s)*EW-1 -: IDX_W];
            assign slot_val[s] = row_word[(SLOTS-s)*EW-IDX_W-1 -: VAL_W];
        end

        // Priority match: walk from the highest slot down so the lowest matching slot wins;
        // in the first word only slots strictly right of the diagonal are eligible.
        always_comb begin
            hit      = 1'b0;
            hit_slot = '0;
            hit_val  = '0;
            for (int s = SLOTS - 1; s >= 0; s--) begin
                if (slot_idx[s] == key_q &&
                    (state_q != S_FIRST || s > int'(diag_q))) begin
                    hit      = 1'b1;
                    hit_slot = SW'(s);
                    hit_val  = slot_val[s];
                end
            end
        end

`ifdef UPDATE_SEARCH_TIMEOUT_EN
        logic [CNT_W-1:0] cnt_q;
        // The word now being accepted is the last one allowed for this search.
        assign limit_hit = (cnt_q == CNT_W'(MAX_WORDS - 1));
`else
        assign limit_hit = 1'b0;
`endif

        // Search FSM: reset, then abort, then start/word handling; results hold until the next start.
        always_ff @(posedge clock_i) begin
            if (!reset_i) begin
                state_q   <= S_IDLE;
                key_q     <= '0;
                diag_q    <= '0;
                found_q   <= 1'b0;
                timeout_q <= 1'b0;
                elem_q    <= '0;
                pos_q     <= '0;
`ifdef UPDATE_SEARCH_TIMEOUT_EN
                cnt_q     <= '0;
`endif
            end else if (abort_i[c]) begin
                state_q   <= S_IDLE;
                found_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i[c]) begin
                            state_q   <= S_FIRST;
                            key_q     <= key_i[c*IDX_W +: IDX_W];
                            diag_q    <= diag_pos_i[c*SW +: SW];
                            found_q   <= 1'b0;
                            timeout_q <= 1'b0;
`ifdef UPDATE_SEARCH_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end
                    end
                    S_FIRST, S_SCAN: begin
                        if (word_valid_i[c]) begin
`ifdef UPDATE_SEARCH_TIMEOUT_EN
                            cnt_q <= cnt_q + 1'b1;
`endif
                            if (hit) begin
                                found_q <= 1'b1;
                                elem_q  <= hit_val;
                                pos_q   <= {row_no, hit_slot};
                                state_q <= S_DONE;
                            end else if (row_end_i[c]) begin
                                state_q <= S_DONE;
                            end else if (limit_hit) begin
                                timeout_q <= 1'b1;
                                state_q   <= S_DONE;
                            end else begin
                                state_q <= S_SCAN;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end

        assign word_ready_o[c]            = searching;
        assign busy_o[c]                  = (state_q != S_IDLE);
        assign done_o[c]                  = (state_q == S_DONE);
        assign found_o[c]                 = found_q;
        assign timeout_o[c]               = timeout_q;
        assign elem_o[c*VAL_W +: VAL_W]   = elem_q;
        assign pos_o[c*PW +: PW]          = pos_q;
    end

endmodule
